// File: rtl/bp_me_mem_latency_stub_pkg.sv
//============================================================================
// Module : bp_me_mem_latency_stub_pkg
// Desc   : CCE memory message types shared by the latency stub and its bench
// Rev    : 1.0
//============================================================================
`default_nettype none

package bp_me_mem_latency_stub_pkg;

   localparam int c_paddr_width           = 40;
   localparam int c_cce_block_width       = 512;
   localparam int c_cce_mem_payload_width = 16;

   typedef enum logic [3:0] {
      e_cce_mem_rd    = 4'b0000,
      e_cce_mem_wr    = 4'b0001,
      e_cce_mem_uc_rd = 4'b0010,
      e_cce_mem_uc_wr = 4'b0011,
      e_cce_mem_pre   = 4'b0100,
      e_cce_mem_amo   = 4'b0101
   } bp_cce_mem_cmd_type_e;

   typedef enum logic [2:0] {
      e_mem_msg_size_1  = 3'd0,
      e_mem_msg_size_2  = 3'd1,
      e_mem_msg_size_4  = 3'd2,
      e_mem_msg_size_8  = 3'd3,
      e_mem_msg_size_16 = 3'd4,
      e_mem_msg_size_32 = 3'd5,
      e_mem_msg_size_64 = 3'd6
   } bp_mem_msg_size_e;

   typedef struct packed {
      bp_cce_mem_cmd_type_e                msg_type;
      logic [c_paddr_width-1:0]            addr;
      bp_mem_msg_size_e                    size;
      logic [c_cce_mem_payload_width-1:0]  payload;
      logic [c_cce_block_width-1:0]        data;
   } bp_cce_mem_msg_s;

   function automatic logic mem_cmd_type_known(input bp_cce_mem_cmd_type_e t);
      case (t)
         e_cce_mem_rd, e_cce_mem_wr, e_cce_mem_uc_rd, e_cce_mem_uc_wr: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

endpackage

`default_nettype wire

// File: rtl/bp_me_mem_latency_stub_if.sv
//============================================================================
// Module : bp_me_mem_latency_stub_if
// Desc   : CCE <-> memory command/response handshake bundle
// Rev    : 1.0
//============================================================================
`default_nettype none

interface bp_me_mem_latency_stub_if;
   import bp_me_mem_latency_stub_pkg::*;

   bp_cce_mem_msg_s mem_cmd;
   logic            mem_cmd_v;
   logic            mem_cmd_yumi;
   bp_cce_mem_msg_s mem_resp;
   logic            mem_resp_v;
   logic            mem_resp_ready;

   modport master (
      output mem_cmd, mem_cmd_v, mem_resp_ready,
      input  mem_cmd_yumi, mem_resp, mem_resp_v
   );

   modport slave (
      input  mem_cmd, mem_cmd_v, mem_resp_ready,
      output mem_cmd_yumi, mem_resp, mem_resp_v
   );

endinterface

`default_nettype wire

// File: rtl/bp_me_mem_latency_stub_storage.sv
//============================================================================
// Module : bp_me_mem_stub_storage
// Desc   : 1rw synchronous block array with per-byte write mask
// Rev    : 1.0
//============================================================================
`default_nettype none

module bp_me_mem_stub_storage #(
   parameter int ELS_P   = 64,
   parameter int WIDTH_P = 512
) (
   input  wire logic                                clk_i,
   input  wire logic                                i_v,
   input  wire logic                                i_w,
   input  wire logic [((ELS_P > 1) ? $clog2(ELS_P) : 1)-1:0] i_addr,
   input  wire logic [WIDTH_P-1:0]                  i_data,
   input  wire logic [WIDTH_P/8-1:0]                i_mask,
   output logic      [WIDTH_P-1:0]                  o_data
);

   localparam int c_bytes = WIDTH_P / 8;

   logic [WIDTH_P-1:0] r_mem [ELS_P];
   logic [WIDTH_P-1:0] r_data;

   // Read data is held until the next read, so it stays valid through WAIT/RESP.
   always_ff @(posedge clk_i) begin
      if (i_v) begin
         if (i_w) begin
            for (int b = 0; b < c_bytes; b++) begin
               if (i_mask[b]) begin
                  r_mem[i_addr][8*b +: 8] <= i_data[8*b +: 8];
               end
            end
         end else begin
            r_data <= r_mem[i_addr];
         end
      end
   end

   assign o_data = r_data;

endmodule

`default_nettype wire

// File: rtl/bp_me_mem_latency_stub.sv
//============================================================================
// Module : bp_me_mem_latency_stub
// Desc   : fixed-latency memory endpoint closing the CCE mem loop
// Rev    : 1.0
//============================================================================
`default_nettype none

module bp_me_mem_latency_stub
   import bp_me_mem_latency_stub_pkg::*;
#(
   parameter int ELS_P     = 64,
   parameter int LATENCY_P = 4
) (
   input  wire logic                 clk_i,
   input  wire logic                 reset_n_i,
   bp_me_mem_latency_stub_if.slave   mem_if,
   output logic                      init_done_o
);

   localparam int c_lg_els       = (ELS_P > 1) ? $clog2(ELS_P) : 1;
   localparam int c_block_bytes  = c_cce_block_width / 8;
   localparam int c_block_offset = (c_block_bytes > 1) ? $clog2(c_block_bytes) : 1;
   localparam int c_cnt_w        = (LATENCY_P > 0) ? $clog2(LATENCY_P + 1) : 1;

   typedef enum logic [2:0] {
      S_INIT   = 3'd0,
      S_IDLE   = 3'd1,
      S_ACCESS = 3'd2,
      S_WAIT   = 3'd3,
      S_RESP   = 3'd4
   } state_e;

   state_e                    r_state;
   logic [c_lg_els-1:0]       r_idx;
   logic [c_cnt_w-1:0]        r_cnt;
   bp_cce_mem_msg_s           r_cmd;
   logic                      r_resp_v;
   logic                      r_init_done;

   logic                          w_cmd_yumi;
   logic [c_lg_els-1:0]           w_cmd_idx;
   int                            w_size_int;
   int                            w_nbytes;
   int                            w_offset;
   logic                          w_mem_v;
   logic                          w_mem_w;
   logic [c_lg_els-1:0]           w_mem_addr;
   logic [c_cce_block_width-1:0]  w_mem_data;
   logic [c_block_bytes-1:0]      w_mem_mask;
   logic [c_cce_block_width-1:0]  w_mem_rdata;
   logic [c_cce_block_width-1:0]  w_sel;
   logic [c_cce_block_width-1:0]  w_resp_data;
   bp_cce_mem_msg_s               w_resp;

   assign w_cmd_yumi = (r_state == S_IDLE) && mem_if.mem_cmd_v;
   assign w_cmd_idx  = r_cmd.addr[c_block_offset +: c_lg_els];

   // Byte window of an uncached access: size-aligned offset, 2^size bytes.
   always_comb begin
      w_size_int = (int'(r_cmd.size) > c_block_offset) ? c_block_offset : int'(r_cmd.size);
      w_nbytes   = 1 << w_size_int;
      w_offset   = int'(r_cmd.addr[c_block_offset-1:0]) & ~(w_nbytes - 1);
   end

   always_comb begin
      w_mem_v    = 1'b0;
      w_mem_w    = 1'b0;
      w_mem_addr = w_cmd_idx;
      w_mem_data = r_cmd.data;
      w_mem_mask = '0;
      case (r_state)
         S_INIT: begin
            w_mem_v    = 1'b1;
            w_mem_w    = 1'b1;
            w_mem_addr = r_idx;
            w_mem_data = '0;
            w_mem_mask = '1;
         end
         S_ACCESS: begin
            case (r_cmd.msg_type)
               e_cce_mem_rd, e_cce_mem_uc_rd: begin
                  w_mem_v = 1'b1;
               end
               e_cce_mem_wr: begin
                  w_mem_v    = 1'b1;
                  w_mem_w    = 1'b1;
                  w_mem_mask = '1;
               end
               e_cce_mem_uc_wr: begin
                  w_mem_v    = 1'b1;
                  w_mem_w    = 1'b1;
                  w_mem_data = r_cmd.data << (8 * w_offset);
                  for (int b = 0; b < c_block_bytes; b++) begin
                     w_mem_mask[b] = (b >= w_offset) && (b < w_offset + w_nbytes);
                  end
               end
               default: w_mem_v = 1'b0;
            endcase
         end
         default: w_mem_v = 1'b0;
      endcase
   end

   bp_me_mem_stub_storage #(
      .ELS_P   (ELS_P),
      .WIDTH_P (c_cce_block_width)
   ) u_storage (
      .clk_i   (clk_i),
      .i_v     (w_mem_v),
      .i_w     (w_mem_w),
      .i_addr  (w_mem_addr),
      .i_data  (w_mem_data),
      .i_mask  (w_mem_mask),
      .o_data  (w_mem_rdata)
   );

   always_comb begin
      w_sel       = w_mem_rdata >> (8 * w_offset);
      w_resp_data = '0;
      case (r_cmd.msg_type)
         e_cce_mem_rd: w_resp_data = w_mem_rdata;
         e_cce_mem_uc_rd: begin
            for (int b = 0; b < c_block_bytes; b++) begin
               w_resp_data[8*b +: 8] = w_sel[8*(b & (w_nbytes - 1)) +: 8];
            end
         end
         default: w_resp_data = '0;
      endcase
      w_resp      = r_cmd;
      w_resp.data = w_resp_data;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_state     <= S_INIT;
         r_idx       <= '0;
         r_cnt       <= '0;
         r_cmd       <= '0;
         r_resp_v    <= 1'b0;
         r_init_done <= 1'b0;
      end else begin
         case (r_state)
            S_INIT: begin
               r_idx <= r_idx + c_lg_els'(1);
               if (r_idx == c_lg_els'(ELS_P - 1)) begin
                  r_state     <= S_IDLE;
                  r_init_done <= 1'b1;
               end
            end
            S_IDLE: begin
               if (w_cmd_yumi) begin
                  r_cmd   <= mem_if.mem_cmd;
                  r_state <= S_ACCESS;
               end
            end
            S_ACCESS: begin
               r_cnt <= c_cnt_w'(LATENCY_P);
               if (LATENCY_P == 0) begin
                  r_state  <= S_RESP;
                  r_resp_v <= 1'b1;
               end else begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               r_cnt <= r_cnt - c_cnt_w'(1);
               if (r_cnt == c_cnt_w'(1)) begin
                  r_state  <= S_RESP;
                  r_resp_v <= 1'b1;
               end
            end
            S_RESP: begin
               if (mem_if.mem_resp_ready) begin
                  r_resp_v <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: r_state <= S_INIT;
         endcase
      end
   end

   assign mem_if.mem_cmd_yumi = w_cmd_yumi;
   assign mem_if.mem_resp_v   = r_resp_v;
   assign mem_if.mem_resp     = w_resp;
   assign init_done_o         = r_init_done;

`ifndef SYNTHESIS
   always_ff @(posedge clk_i) begin
      if (reset_n_i && (r_state == S_ACCESS)) begin
         assert (mem_cmd_type_known(r_cmd.msg_type));
         assert (int'(r_cmd.size) <= c_block_offset);
      end
   end
`endif

endmodule

`default_nettype wire

// File: tb/tb_bp_me_mem_latency_stub.sv
//============================================================================
// Module : tb_bp_me_mem_latency_stub
// Desc   : self-checking bench for the fixed-latency memory stub
// Rev    : 1.0
//============================================================================
`default_nettype none

module tb_bp_me_mem_latency_stub;
   import bp_me_mem_latency_stub_pkg::*;

   logic clk;
   logic rst_n;
   logic done_a;
   logic done_z;
   int   n_checks = 0;
   int   n_err    = 0;

   // Byte-level reference memory per unit: 0 = latency 4, 1 = latency 0.
   logic [7:0] mem_model [2][64][64];

   bp_me_mem_latency_stub_if mif_a ();
   bp_me_mem_latency_stub_if mif_z ();

   bp_me_mem_latency_stub #(.ELS_P(64), .LATENCY_P(4)) dut_a (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .mem_if      (mif_a.slave),
      .init_done_o (done_a)
   );

   bp_me_mem_latency_stub #(.ELS_P(64), .LATENCY_P(0)) dut_z (
      .clk_i       (clk),
      .reset_n_i   (rst_n),
      .mem_if      (mif_z.slave),
      .init_done_o (done_z)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic get_yumi(input int u);
      return (u == 0) ? mif_a.mem_cmd_yumi : mif_z.mem_cmd_yumi;
   endfunction

   function automatic logic get_resp_v(input int u);
      return (u == 0) ? mif_a.mem_resp_v : mif_z.mem_resp_v;
   endfunction

   function automatic bp_cce_mem_msg_s get_resp(input int u);
      return (u == 0) ? mif_a.mem_resp : mif_z.mem_resp;
   endfunction

   task automatic drive_cmd(input int u, input bp_cce_mem_msg_s c, input logic v);
      if (u == 0) begin mif_a.mem_cmd = c; mif_a.mem_cmd_v = v; end
      else        begin mif_z.mem_cmd = c; mif_z.mem_cmd_v = v; end
   endtask

   task automatic set_ready(input int u, input logic r);
      if (u == 0) mif_a.mem_resp_ready = r;
      else        mif_z.mem_resp_ready = r;
   endtask

   function automatic bp_cce_mem_msg_s mk(input bp_cce_mem_cmd_type_e t, input logic [39:0] a,
                                          input int sz, input logic [511:0] d);
      bp_cce_mem_msg_s c;
      c.msg_type = t;
      c.addr     = a;
      c.size     = bp_mem_msg_size_e'(sz[2:0]);
      c.payload  = 16'($urandom);
      c.data     = d;
      return c;
   endfunction

   function automatic bp_cce_mem_msg_s rand_cmd(input bit reads_only);
      bp_cce_mem_cmd_type_e t;
      logic [39:0]          a;
      logic [511:0]         d;
      int                   k;
      k = reads_only ? 2 * $urandom_range(0, 1) : $urandom_range(0, 3);
      case (k)
         0:       t = e_cce_mem_rd;
         1:       t = e_cce_mem_wr;
         2:       t = e_cce_mem_uc_rd;
         default: t = e_cce_mem_uc_wr;
      endcase
      a = {8'($urandom), 20'($urandom), 6'($urandom_range(0, 7)), 6'($urandom)};
      for (int i = 0; i < 16; i++) d[32*i +: 32] = $urandom;
      return mk(t, a, $urandom_range(0, 6), d);
   endfunction

   // Applies a command to the byte model and returns the response data it implies.
   function automatic logic [511:0] model_exec(input int u, input bp_cce_mem_msg_s c);
      int idx, n, off;
      logic [511:0] r;
      r   = '0;
      idx = int'(c.addr[11:6]);
      n   = 1 << int'(c.size);
      off = (int'(c.addr[5:0]) / n) * n;
      case (c.msg_type)
         e_cce_mem_rd:    for (int b = 0; b < 64; b++) r[8*b +: 8] = mem_model[u][idx][b];
         e_cce_mem_uc_rd: for (int b = 0; b < 64; b++) r[8*b +: 8] = mem_model[u][idx][off + (b % n)];
         e_cce_mem_wr:    for (int b = 0; b < 64; b++) mem_model[u][idx][b] = c.data[8*b +: 8];
         e_cce_mem_uc_wr: for (int k = 0; k < n; k++) mem_model[u][idx][off + k] = c.data[8*k +: 8];
         default: r = '0;
      endcase
      return r;
   endfunction

   task automatic clear_model();
      for (int u = 0; u < 2; u++)
         for (int i = 0; i < 64; i++)
            for (int b = 0; b < 64; b++) mem_model[u][i][b] = 8'h00;
   endtask

   task automatic wait_init(input string tag);
      int cyc, bad;
      bp_cce_mem_msg_s c;
      cyc = 0;
      bad = 0;
      c   = mk(e_cce_mem_rd, 40'h0, 0, '0);
      drive_cmd(0, c, 1'b1);
      drive_cmd(1, c, 1'b1);
      while (!done_a && cyc < 200) begin
         @(posedge clk); #1;
         cyc++;
         if (!done_a && (get_yumi(0) || get_yumi(1))) bad++;
      end
      drive_cmd(0, c, 1'b0);
      drive_cmd(1, c, 1'b0);
      chk({tag, "_cycles"}, cyc, 64);
      chk({tag, "_yumi_during_init"}, bad, 0);
      chk({tag, "_done_z"}, done_z, 1'b1);
   endtask

   // One command through unit u: accept, latency, header echo, data, optional backpressure.
   task automatic xact(input int u, input bp_cce_mem_msg_s c, input int exp_lat, input int hold,
                       input string tag, output logic [511:0] rdata);
      logic [511:0]    exp_d;
      bp_cce_mem_msg_s r, snap;
      int              cyc, bad;
      @(negedge clk);
      drive_cmd(u, c, 1'b1);
      #1;
      cyc = 0;
      while (!get_yumi(u) && cyc < 50) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk({tag, "_accept"}, get_yumi(u), 1'b1);
      exp_d = model_exec(u, c);
      @(negedge clk);
      drive_cmd(u, c, 1'b0);
      #1;
      cyc = 1;
      while (!get_resp_v(u) && cyc < 50) begin
         @(negedge clk); #1;
         cyc++;
      end
      chk({tag, "_latency"}, cyc, exp_lat);
      r = get_resp(u);
      rdata = r.data;
      chk({tag, "_header"}, {r.msg_type, r.addr, r.size, r.payload},
                            {c.msg_type, c.addr, c.size, c.payload});
      chk({tag, "_data"}, r.data, exp_d);
      if (hold > 0) begin
         snap = r;
         bad  = 0;
         drive_cmd(u, mk(e_cce_mem_rd, 40'h40, 6, '0), 1'b1);
         for (int i = 0; i < hold; i++) begin
            @(negedge clk); #1;
            if (!get_resp_v(u) || (get_resp(u) !== snap) || get_yumi(u)) bad++;
         end
         drive_cmd(u, snap, 1'b0);
         chk({tag, "_backpressure_stable"}, bad, 0);
      end
      set_ready(u, 1'b1);
      @(posedge clk); #1;
      set_ready(u, 1'b0);
      chk({tag, "_resp_v_drop"}, get_resp_v(u), 1'b0);
   endtask

   initial begin
      logic [511:0]    rd;
      bp_cce_mem_msg_s q[6];
      logic [511:0]    expq[$];
      int              ycyc[$];
      int              k, cyc, last_y, nresp;
      bit              adv;

      rst_n = 1'b0;
      clear_model();
      set_ready(0, 1'b0);
      set_ready(1, 1'b0);
      drive_cmd(0, mk(e_cce_mem_rd, 40'h0, 0, '0), 1'b1);
      drive_cmd(1, mk(e_cce_mem_rd, 40'h0, 0, '0), 1'b1);
      repeat (3) @(negedge clk);
      #1;
      chk("reset_done", done_a, 1'b0);
      chk("reset_yumi", get_yumi(0), 1'b0);
      chk("reset_resp_v", get_resp_v(0), 1'b0);

      @(negedge clk);
      rst_n = 1'b1;
      wait_init("init");

      // Cached write then read of one block.
      xact(0, mk(e_cce_mem_wr, 40'h80, 6, {64{8'hA5}}), 6, 0, "wr80", rd);
      chk("wr80_zero_data", rd, '0);
      xact(0, mk(e_cce_mem_rd, 40'h80, 6, '0), 6, 0, "rd80", rd);
      chk("rd80_literal", rd, {64{8'hA5}});

      // Uncached word write / read inside the same block.
      xact(0, mk(e_cce_mem_uc_wr, 40'h84, 2, {480'h0, 32'hDEADBEEF}), 6, 0, "ucwr84", rd);
      xact(0, mk(e_cce_mem_uc_rd, 40'h84, 2, '0), 6, 0, "ucrd84", rd);
      chk("ucrd84_literal", rd, {16{32'hDEADBEEF}});
      xact(0, mk(e_cce_mem_rd, 40'h80, 6, '0), 6, 10, "rd80_bp", rd);
      chk("rd80_after_uc_literal", rd, {{56{8'hA5}}, 32'hDEADBEEF, 32'hA5A5A5A5});

      for (int i = 0; i < 40; i++) xact(0, rand_cmd(1'b0), 6, 0, "rand_a", rd);

      // Zero-latency unit: seed some data, then back-to-back reads with v held high.
      for (int i = 0; i < 12; i++) xact(1, rand_cmd(1'b0), 2, 0, "rand_z", rd);
      for (int i = 0; i < 6; i++) q[i] = rand_cmd(1'b1);
      @(negedge clk);
      drive_cmd(1, q[0], 1'b1);
      set_ready(1, 1'b1);
      k = 0; cyc = 0; last_y = -1; nresp = 0; adv = 1'b0;
      while ((k < 6 || nresp < 6) && cyc < 100) begin
         #1;
         if (get_resp_v(1) && expq.size() > 0) begin
            chk("b2b_data", get_resp(1).data, expq.pop_front());
            chk("b2b_latency", cyc - ycyc.pop_front(), 2);
            nresp++;
         end
         if (get_yumi(1)) begin
            if (last_y >= 0) chk("b2b_accept_gap", cyc - last_y, 3);
            last_y = cyc;
            expq.push_back(model_exec(1, q[k]));
            ycyc.push_back(cyc);
            k++;
            adv = 1'b1;
         end
         @(negedge clk);
         cyc++;
         if (adv) begin
            adv = 1'b0;
            drive_cmd(1, q[(k < 6) ? k : 5], k < 6);
         end
      end
      set_ready(1, 1'b0);
      chk("b2b_accepts", k, 6);
      chk("b2b_responses", nresp, 6);

      // Reset while a write is waiting out its latency.
      @(negedge clk);
      drive_cmd(0, mk(e_cce_mem_wr, 40'h1C0, 6, {16{32'h12345678}}), 1'b1);
      #1;
      chk("mid_accept", get_yumi(0), 1'b1);
      @(negedge clk);
      drive_cmd(0, mk(e_cce_mem_rd, 40'h0, 0, '0), 1'b0);
      repeat (2) @(negedge clk);
      #2;
      rst_n = 1'b0;
      drive_cmd(0, mk(e_cce_mem_rd, 40'h0, 0, '0), 1'b1);
      #1;
      chk("mid_done_drop", done_a, 1'b0);
      chk("mid_resp_v", get_resp_v(0), 1'b0);
      chk("mid_yumi", get_yumi(0), 1'b0);
      repeat (8) @(negedge clk);
      #1;
      chk("mid_resp_v_held", get_resp_v(0), 1'b0);
      clear_model();
      @(negedge clk);
      rst_n = 1'b1;
      wait_init("reinit");
      xact(0, mk(e_cce_mem_rd, 40'h80, 6, '0), 6, 0, "post_rd80", rd);
      chk("post_rd80_zero", rd, '0);
      xact(0, mk(e_cce_mem_rd, 40'h1C0, 6, '0), 6, 0, "post_rd1c0", rd);
      chk("post_rd1c0_zero", rd, '0);

      $display("Result: errors=%0d of %0d checks", n_err, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
